// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target mapping bus transfers onto a byte register file
// Ports:
//   clk_i, rst_i       system clock (>=16x SCL), synchronous active-high reset
//   scl_i, sda_i       asynchronous pad inputs
//   sda_o, sda_dir_o   open-drain SDA: sda_o tied 0, sda_dir_o=1 pulls the line low
//   mem_we_o/mem_re_o  one-cycle register write/read strobes at mem_addr_o
//   mem_wdata_o        write data, valid with mem_we_o
//   mem_rdata_i        read data, valid one clk after mem_re_o
//   busy_o             addressed transaction in progress
//   stop_o             one-cycle pulse per detected STOP
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         REG_AW   = 8,
   parameter int         FILT_LEN = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_o,
   output logic              sda_dir_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   output logic [REG_AW-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              busy_o,
   output logic              stop_o
);
   localparam int            CW       = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_DATA_ACK, S_WDATA,
      S_RD_LOAD, S_RD_LATCH, S_TX_WAIT, S_RDATA, S_RD_ACK, S_WAIT
   } state_t;

   logic [1:0]        r_scl_sync, r_sda_sync;
   logic [CW-1:0]     r_scl_cnt, r_sda_cnt;
   logic              r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]        r_shreg, w_shreg_nxt;
   logic [REG_AW-1:0] r_ptr, w_ptr_nxt;
   logic              r_rw, w_rw_nxt;
   logic              r_sda_dir, w_sda_dir_nxt;
   logic              r_we, w_we_nxt;
   logic              r_re, w_re_nxt;
   logic [REG_AW-1:0] r_addr, w_addr_nxt;
   logic [7:0]        r_wdata, w_wdata_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_stop, w_stop_nxt;

   logic              w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]        w_byte;

   // Synchronise, then only let a level through after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_cnt  <= '0;
         r_sda_cnt  <= '0;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_fd   <= 1'b1;
         r_sda_fd   <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_i};
         r_sda_sync <= {r_sda_sync[0], sda_i};
         if (r_scl_sync[1] == r_scl_f) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == FILT_MAX) begin
            r_scl_f   <= r_scl_sync[1];
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + CW'(1);
         end
         if (r_sda_sync[1] == r_sda_f) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == FILT_MAX) begin
            r_sda_f   <= r_sda_sync[1];
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + CW'(1);
         end
         r_scl_fd <= r_scl_f;
         r_sda_fd <= r_sda_f;
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_fd;
   assign w_scl_fall = ~r_scl_f & r_scl_fd;
   // SCL must be high on both samples so an SCL edge never masquerades as START/STOP.
   assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
   assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
   assign w_byte     = {r_shreg[6:0], r_sda_f};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shreg   <= '0;
         r_ptr     <= '0;
         r_rw      <= 1'b0;
         r_sda_dir <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shreg   <= w_shreg_nxt;
         r_ptr     <= w_ptr_nxt;
         r_rw      <= w_rw_nxt;
         r_sda_dir <= w_sda_dir_nxt;
         r_we      <= w_we_nxt;
         r_re      <= w_re_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_busy    <= w_busy_nxt;
         r_stop    <= w_stop_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shreg_nxt   = r_shreg;
      w_ptr_nxt     = r_ptr;
      w_rw_nxt      = r_rw;
      w_sda_dir_nxt = r_sda_dir;
      w_we_nxt      = 1'b0;
      w_re_nxt      = 1'b0;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_busy_nxt    = r_busy;
      w_stop_nxt    = 1'b0;
      if (w_stop) begin
         w_state_nxt   = S_IDLE;
         w_sda_dir_nxt = 1'b0;
         w_busy_nxt    = 1'b0;
         w_stop_nxt    = 1'b1;
      end else if (w_start) begin
         // Release wins over any ack or data bit that was being driven.
         w_state_nxt   = S_ADDR;
         w_bit_cnt_nxt = '0;
         w_sda_dir_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: if (w_scl_rise) begin
               w_shreg_nxt   = w_byte;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  w_bit_cnt_nxt = '0;
                  // General call (0x00) is never acknowledged.
                  if (w_byte[7:1] == DEV_ADDR && w_byte[7:1] != 7'h00) begin
                     w_busy_nxt  = 1'b1;
                     w_rw_nxt    = w_byte[0];
                     w_state_nxt = S_ADDR_ACK;
                  end else begin
                     w_busy_nxt  = 1'b0;
                     w_state_nxt = S_WAIT;
                  end
               end
            end
            S_ADDR_ACK: if (w_scl_fall) begin
               if (!r_sda_dir) begin
                  w_sda_dir_nxt = 1'b1;
                  // Reads prefetch during the ack slot; TX_WAIT swaps the ack for bit 7.
                  if (r_rw) begin
                     w_state_nxt = S_RD_LOAD;
                     w_re_nxt    = 1'b1;
                     w_addr_nxt  = r_ptr;
                  end
               end else begin
                  w_sda_dir_nxt = 1'b0;
                  w_state_nxt   = S_PTR;
               end
            end
            S_PTR: if (w_scl_rise) begin
               w_shreg_nxt   = w_byte;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  w_bit_cnt_nxt = '0;
                  w_ptr_nxt     = REG_AW'(w_byte);
                  w_state_nxt   = S_DATA_ACK;
               end
            end
            S_DATA_ACK: if (w_scl_fall) begin
               if (!r_sda_dir) begin
                  w_sda_dir_nxt = 1'b1;
               end else begin
                  w_sda_dir_nxt = 1'b0;
                  w_state_nxt   = S_WDATA;
               end
            end
            S_WDATA: if (w_scl_rise) begin
               w_shreg_nxt   = w_byte;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  w_bit_cnt_nxt = '0;
                  w_we_nxt      = 1'b1;
                  w_addr_nxt    = r_ptr;
                  w_wdata_nxt   = w_byte;
                  w_ptr_nxt     = r_ptr + REG_AW'(1);
                  w_state_nxt   = S_DATA_ACK;
               end
            end
            S_RD_LOAD: w_state_nxt = S_RD_LATCH;
            S_RD_LATCH: begin
               w_shreg_nxt = mem_rdata_i;
               w_ptr_nxt   = r_ptr + REG_AW'(1);
               w_state_nxt = S_TX_WAIT;
            end
            S_TX_WAIT: if (w_scl_fall) begin
               w_sda_dir_nxt = ~r_shreg[7];
               w_shreg_nxt   = {r_shreg[6:0], 1'b0};
               w_bit_cnt_nxt = 4'd1;
               w_state_nxt   = S_RDATA;
            end
            S_RDATA: if (w_scl_fall) begin
               if (r_bit_cnt == 4'd8) begin
                  w_sda_dir_nxt = 1'b0;
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = S_RD_ACK;
               end else begin
                  w_sda_dir_nxt = ~r_shreg[7];
                  w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
            S_RD_ACK: if (w_scl_rise) begin
               if (!r_sda_f) begin
                  w_state_nxt = S_RD_LOAD;
                  w_re_nxt    = 1'b1;
                  w_addr_nxt  = r_ptr;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_o       = 1'b0;
   assign sda_dir_o   = r_sda_dir;
   assign mem_we_o    = r_we;
   assign mem_re_o    = r_re;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign busy_o      = r_busy;
   assign stop_o      = r_stop;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - bench for i2c_target_regfile: bus master, register memory, checks
module tb_i2c_target_regfile;
   localparam int Q = 16;

   typedef enum logic [1:0] {OP_START, OP_STOP, OP_WR, OP_RD} op_t;
   typedef struct packed {
      op_t        op;
      logic [7:0] data;      // byte to send, or master ack bit for OP_RD
      logic [7:0] exp;       // expected ack bit (OP_WR) or read byte (OP_RD)
      logic       exp_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_i, scl_m, sda_m, sda_bus;
   logic       sda_o, sda_dir_o, mem_we_o, mem_re_o, busy_o, stop_o;
   logic [7:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   logic [7:0] mem [256];
   logic [7:0] wr_addr_q[$], wr_data_q[$], rd_q[$];
   vec_t       vecs[$];
   int         stop_cnt = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   assign sda_bus = sda_m & (sda_dir_o ? sda_o : 1'b1);

   i2c_target_regfile dut (
      .clk_i(clk), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_dir_o(sda_dir_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .stop_o(stop_o)
   );

   always @(negedge clk) begin
      if (mem_we_o) begin
         wr_addr_q.push_back(mem_addr_o);
         wr_data_q.push_back(mem_wdata_o);
         mem[mem_addr_o] = mem_wdata_o;
      end
      if (mem_re_o) begin
         rd_q.push_back(mem_addr_o);
         mem_rdata_i = mem[mem_addr_o];
      end
      if (stop_o) stop_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   // g=1 adds a 1-clk SCL low pulse and a 1-clk SDA inversion while SCL is high.
   task automatic send_bit(input logic b, input logic g);
      sda_m = b; wait_clk(Q);
      scl_m = 1'b1;
      if (g) begin
         wait_clk(4); scl_m = 1'b0; wait_clk(1); scl_m = 1'b1;
         wait_clk(4); sda_m = ~b;   wait_clk(1); sda_m = b;
         wait_clk(2*Q - 10);
      end else begin
         wait_clk(2*Q);
      end
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = sda_bus;  wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, input logic g, output logic ack);
      for (int k = 7; k >= 0; k--) send_bit(d[k], g);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic bb;
      for (int k = 7; k >= 0; k--) begin
         recv_bit(bb);
         d[k] = bb;
      end
      send_bit(m_ack, 1'b0);
   endtask

   task automatic add(input op_t op, input logic [7:0] data, input logic [7:0] exp, input logic bsy);
      vec_t v;
      v.op = op; v.data = data; v.exp = exp; v.exp_busy = bsy;
      vecs.push_back(v);
   endtask

   initial begin
      logic       b;
      logic [7:0] d;
      int         sc;
      logic [7:0] exp_wa [6] = '{8'h10, 8'h11, 8'h12, 8'hFE, 8'hFF, 8'h00};
      logic [7:0] exp_wd [6] = '{8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB, 8'hCC};
      logic [7:0] exp_ra [3] = '{8'h10, 8'h11, 8'h12};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem_rdata_i = 8'h00;
      scl_m = 1'b1; sda_m = 1'b1; rst_i = 1'b1;
      wait_clk(5);
      check("rst_sda_o", sda_o, 0);
      check("rst_sda_dir", sda_dir_o, 0);
      check("rst_we", mem_we_o, 0);
      check("rst_re", mem_re_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_wdata", mem_wdata_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_stop", stop_o, 0);
      rst_i = 1'b0;
      wait_clk(10);

      // write 0x11/0x22/0x33 from pointer 0x10
      add(OP_START, 8'h00, 8'h00, 1'b0); add(OP_WR, 8'hA0, 8'h00, 1'b1);
      add(OP_WR, 8'h10, 8'h00, 1'b1);    add(OP_WR, 8'h11, 8'h00, 1'b1);
      add(OP_WR, 8'h22, 8'h00, 1'b1);    add(OP_WR, 8'h33, 8'h00, 1'b1);
      add(OP_STOP, 8'h00, 8'h00, 1'b0);
      // random read of three bytes from 0x10
      add(OP_START, 8'h00, 8'h00, 1'b0); add(OP_WR, 8'hA0, 8'h00, 1'b1);
      add(OP_WR, 8'h10, 8'h00, 1'b1);    add(OP_START, 8'h00, 8'h00, 1'b1);
      add(OP_WR, 8'hA1, 8'h00, 1'b1);    add(OP_RD, 8'h00, 8'h11, 1'b1);
      add(OP_RD, 8'h00, 8'h22, 1'b1);    add(OP_RD, 8'h01, 8'h33, 1'b1);
      add(OP_STOP, 8'h00, 8'h00, 1'b0);
      // wrong address, then general call
      add(OP_START, 8'h00, 8'h00, 1'b0); add(OP_WR, 8'hA2, 8'h01, 1'b0);
      add(OP_WR, 8'h55, 8'h01, 1'b0);    add(OP_STOP, 8'h00, 8'h00, 1'b0);
      add(OP_START, 8'h00, 8'h00, 1'b0); add(OP_WR, 8'h00, 8'h01, 1'b0);
      add(OP_STOP, 8'h00, 8'h00, 1'b0);
      // pointer wrap
      add(OP_START, 8'h00, 8'h00, 1'b0); add(OP_WR, 8'hA0, 8'h00, 1'b1);
      add(OP_WR, 8'hFE, 8'h00, 1'b1);    add(OP_WR, 8'hAA, 8'h00, 1'b1);
      add(OP_WR, 8'hBB, 8'h00, 1'b1);    add(OP_WR, 8'hCC, 8'h00, 1'b1);
      add(OP_STOP, 8'h00, 8'h00, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_START: i2c_start();
            OP_STOP: begin
               sc = stop_cnt;
               i2c_stop();
               wait_clk(8);
               check($sformatf("v%0d_stop_pulses", i), stop_cnt - sc, 1);
            end
            OP_WR: begin
               write_byte(vecs[i].data, 1'b0, b);
               check($sformatf("v%0d_ack", i), b, vecs[i].exp[0]);
            end
            default: begin
               read_byte(vecs[i].data[0], d);
               check($sformatf("v%0d_rdata", i), d, vecs[i].exp);
               if (vecs[i].data[0]) check($sformatf("v%0d_release_after_nack", i), sda_dir_o, 0);
            end
         endcase
         check($sformatf("v%0d_busy", i), busy_o, vecs[i].exp_busy);
      end

      check("wr_count", wr_addr_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < wr_addr_q.size()) begin
            check($sformatf("wr%0d_addr", i), wr_addr_q[i], exp_wa[i]);
            check($sformatf("wr%0d_data", i), wr_data_q[i], exp_wd[i]);
         end
      end
      check("rd_count", rd_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < rd_q.size()) check($sformatf("rd%0d_addr", i), rd_q[i], exp_ra[i]);
      end

      // glitches on SCL and SDA while SCL is high
      wr_addr_q.delete(); wr_data_q.delete(); sc = stop_cnt;
      i2c_start();
      write_byte(8'hA0, 1'b0, b); check("gl_addr_ack", b, 0);
      write_byte(8'h40, 1'b1, b); check("gl_ptr_ack", b, 0);
      write_byte(8'h5A, 1'b1, b); check("gl_data_ack", b, 0);
      check("gl_no_stop", stop_cnt - sc, 0);
      check("gl_busy", busy_o, 1);
      i2c_stop();
      check("gl_wr_count", wr_addr_q.size(), 1);
      if (wr_addr_q.size() > 0) begin
         check("gl_wr_addr", wr_addr_q[0], 8'h40);
         check("gl_wr_data", wr_data_q[0], 8'h5A);
      end

      // reset halfway through a data byte: no write, target silent afterwards
      wr_addr_q.delete(); wr_data_q.delete();
      i2c_start();
      write_byte(8'hA0, 1'b0, b);
      write_byte(8'h30, 1'b0, b);
      for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
      rst_i = 1'b1; wait_clk(1);
      check("abw_busy", busy_o, 0);
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) send_bit(1'b0, 1'b0);
      recv_bit(b); check("abw_no_ack", b, 1);
      i2c_stop();
      check("abw_no_write", wr_addr_q.size(), 0);

      // reset while the target drives a 0 data bit
      rd_q.delete();
      i2c_start();
      write_byte(8'hA0, 1'b0, b);
      write_byte(8'h10, 1'b0, b);
      i2c_start();
      write_byte(8'hA1, 1'b0, b); check("abr_addr_ack", b, 0);
      recv_bit(b); check("abr_bit7", b, 0);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      check("abr_driving_low", sda_dir_o, 1);
      rst_i = 1'b1; wait_clk(1);
      check("abr_released", sda_dir_o, 0);
      check("abr_busy", busy_o, 0);
      check("abr_we", mem_we_o, 0);
      rst_i = 1'b0;
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
      i2c_stop();
      check("abr_rd_count", rd_q.size(), 1);
      if (rd_q.size() > 0) check("abr_rd_addr", rd_q[0], 8'h10);

      // pointer restarts at 0 after reset
      rd_q.delete();
      i2c_start();
      write_byte(8'hA1, 1'b0, b); check("p0_addr_ack", b, 0);
      read_byte(1'b1, d);         check("p0_rdata", d, 8'hCC);
      i2c_stop();
      check("p0_rd_count", rd_q.size(), 1);
      if (rd_q.size() > 0) check("p0_rd_addr", rd_q[0], 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
